// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder:
// prefix-FSM states, special byte values and the event record.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0
   } ps2_state_e;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_00 = 8'h00;
   localparam logic [7:0] BYTE_FF = 8'hFF;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // 00 and FF are keyboard error/overrun bytes; they abort any prefix.
   function automatic logic is_flush_byte(input logic [7:0] b);
      return (b == BYTE_00) || (b == BYTE_FF);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small event FIFO with valid/ready pop and a sticky overflow flag.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  ps2_evt_t i_data,
   input  logic     i_pop,
   output logic     o_valid,
   output ps2_evt_t o_data,
   output logic     o_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_overflow;
   ps2_evt_t         r_mem [FIFO_DEPTH];

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   always_comb begin
      w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
      w_pop  = i_pop && (r_count != '0);
      w_push = i_push && (!w_full || w_pop);
      w_drop = i_push && w_full && !w_pop;
   end

   // Pointers are PTR_W bits wide, so they wrap modulo the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Storage is not reset; the head is masked so outputs read zero when empty.
   always_comb begin
      o_valid    = (r_count != '0);
      o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
      o_overflow = r_overflow;
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the two-byte PS/2 receiver window into make/break events with E0
// extension, via synchronizer, stability filter, prefix FSM and event FIFO.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] code_vector,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [7:0]  evt_code,
   output logic        evt_ext,
   output logic        evt_break,
   output logic        overflow
);

   localparam int STB_W = $clog2(STABLE_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [15:0]      r_sync1;
   logic [15:0]      r_sync2;
   logic [15:0]      r_hold;
   logic [15:0]      r_accepted;
   logic [STB_W-1:0] r_stb_cnt;
   logic             r_strobe;
   logic [TMO_W-1:0] r_tmo_cnt;
   ps2_state_e       r_state;

   logic [STB_W-1:0] w_stb_next;
   logic             w_fire;
   logic             w_timeout;
   logic [7:0]       w_byte;
   ps2_state_e       w_state_next;
   logic             w_push;
   ps2_evt_t         w_evt;
   ps2_evt_t         w_head;

   // w_stb_next counts how many cycles r_sync2 has held its current value,
   // saturating at STABLE_CYCLES so each stable value can fire only once.
   always_comb begin
      if (r_sync2 != r_hold)
         w_stb_next = STB_W'(1);
      else if (r_stb_cnt == STB_W'(STABLE_CYCLES))
         w_stb_next = r_stb_cnt;
      else
         w_stb_next = r_stb_cnt + 1'b1;
      w_fire = (w_stb_next == STB_W'(STABLE_CYCLES)) && (r_sync2 != r_accepted);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_hold     <= '0;
         r_accepted <= '0;
         r_stb_cnt  <= '0;
         r_strobe   <= 1'b0;
      end else begin
         r_sync1   <= code_vector;
         r_sync2   <= r_sync1;
         r_hold    <= r_sync2;
         r_stb_cnt <= w_stb_next;
         r_strobe  <= w_fire;
         if (w_fire) r_accepted <= r_sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || r_strobe || (r_state == IDLE))
         r_tmo_cnt <= '0;
      else
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end

   assign w_timeout = (r_state != IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign w_byte    = r_accepted[7:0];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      w_evt        = '0;
      w_evt.code   = w_byte;
      if (r_strobe) begin
         if (is_flush_byte(w_byte)) begin
            w_state_next = IDLE;
         end else if (w_byte == BYTE_E0) begin
            w_state_next = GOT_E0;
         end else if (w_byte == BYTE_F0) begin
            case (r_state)
               GOT_E0, GOT_E0F0: w_state_next = GOT_E0F0;
               default:          w_state_next = GOT_F0;
            endcase
         end else begin
            w_push       = 1'b1;
            w_state_next = IDLE;
            case (r_state)
               GOT_E0:   w_evt.ext = 1'b1;
               GOT_F0:   w_evt.brk = 1'b1;
               GOT_E0F0: begin
                  w_evt.ext = 1'b1;
                  w_evt.brk = 1'b1;
               end
               default: ;
            endcase
         end
      end else if (w_timeout) begin
         w_state_next = IDLE;
      end
   end

   ps2_event_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_data     (w_evt),
      .i_pop      (evt_ready),
      .o_valid    (evt_valid),
      .o_data     (w_head),
      .o_overflow (overflow)
   );

   assign evt_code  = w_head.code;
   assign evt_ext   = w_head.ext;
   assign evt_break = w_head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios plus a
// randomized byte stream checked against a prefix-flag reference model.
module tb_ps2_scancode_decoder;
   import ps2_pkg::*;

   localparam int STABLE = 4;
   localparam int TMO    = 200;
   localparam int DEPTH  = 4;
   localparam int HOLD   = STABLE + 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] code_vector;
   logic        evt_valid;
   logic        evt_ready;
   logic [7:0]  evt_code;
   logic        evt_ext;
   logic        evt_break;
   logic        overflow;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  tb_prev  = 8'h00;

   always #5 clk = ~clk;

   ps2_scancode_decoder #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .code_vector (code_vector),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_code    (evt_code),
      .evt_ext     (evt_ext),
      .evt_break   (evt_break),
      .overflow    (overflow)
   );

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      evt_ready   = 1'b0;
      code_vector = 16'h0000;
      tb_prev     = 8'h00;
      tick(3);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      code_vector = {tb_prev, b};
      tb_prev     = b;
      tick(HOLD);
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      evt_ready   = 1'b0;
      code_vector = 16'h0000;
      tick(2);
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
      checks++; if (evt_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", evt_code); end
      checks++; if (evt_ext !== 1'b0) begin failures++; $display("FAIL reset_ext got=%0b exp=0", evt_ext); end
      checks++; if (evt_break !== 1'b0) begin failures++; $display("FAIL reset_break got=%0b exp=0", evt_break); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_latency();
      logic exp_v;
      evt_ready   = 1'b1;
      code_vector = 16'h001C;
      tb_prev     = 8'h1C;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         exp_v = (k == 3 + STABLE);
         checks++;
         if (evt_valid !== exp_v) begin
            failures++; $display("FAIL latency_valid cycle=%0d got=%0b exp=%0b", k, evt_valid, exp_v);
         end
         if (k == 3 + STABLE) begin
            checks++;
            if ({evt_code, evt_ext, evt_break} !== {8'h1C, 1'b0, 1'b0}) begin
               failures++; $display("FAIL latency_event got=%h/%0b/%0b exp=1c/0/0", evt_code, evt_ext, evt_break);
            end
         end
      end
      evt_ready = 1'b0;
      tick(2);
   endtask

   task automatic test_ext_break();
      evt_ready = 1'b0;
      send_byte(BYTE_E0);
      send_byte(BYTE_F0);
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL prefix_no_event got=%0b exp=0", evt_valid); end
      send_byte(8'h75);
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
         failures++; $display("FAIL ext_break got=%0b/%h/%0b/%0b exp=1/75/1/1", evt_valid, evt_code, evt_ext, evt_break);
      end
      pop_one();
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL ext_break_single got=%0b exp=0", evt_valid); end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [5];
      codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
      apply_reset();
      for (int i = 0; i < 5; i++) send_byte(codes[i]);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0b exp=1", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, codes[i], 1'b0, 1'b0}) begin
            failures++; $display("FAIL overflow_drain%0d got=%0b/%h exp=1/%h", i, evt_valid, evt_code, codes[i]);
         end
         pop_one();
      end
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL overflow_empty got=%0b exp=0", evt_valid); end
      pop_one();
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_codes [4];
      exp_codes = '{8'h1D, 8'h24, 8'h2D, 8'h3A};
      apply_reset();
      send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_no_overflow got=%0b exp=0", overflow); end
      code_vector = {tb_prev, 8'h3A};
      tb_prev     = 8'h3A;
      tick(2 + STABLE);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      tick(HOLD);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL push_pop_overflow got=%0b exp=0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if ({evt_valid, evt_code} !== {1'b1, exp_codes[i]}) begin
            failures++; $display("FAIL push_pop_drain%0d got=%0b/%h exp=1/%h", i, evt_valid, evt_code, exp_codes[i]);
         end
         pop_one();
      end
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL push_pop_empty got=%0b exp=0", evt_valid); end
   endtask

   task automatic test_timeout();
      apply_reset();
      send_byte(BYTE_E0);
      tick(TMO + 10);
      send_byte(8'h1C);
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
         failures++; $display("FAIL timeout_e0 got=%0b/%h/%0b/%0b exp=1/1c/0/0", evt_valid, evt_code, evt_ext, evt_break);
      end
      pop_one();
      send_byte(BYTE_E0);
      send_byte(8'h1C);
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b1, 1'b0}) begin
         failures++; $display("FAIL no_timeout_e0 got=%0b/%h/%0b/%0b exp=1/1c/1/0", evt_valid, evt_code, evt_ext, evt_break);
      end
      pop_one();
   endtask

   task automatic test_reset_mid_prefix();
      apply_reset();
      send_byte(8'h2A);
      checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%0b exp=1", evt_valid); end
      send_byte(BYTE_F0);
      rst         = 1'b1;
      code_vector = {BYTE_F0, 8'h1C};
      tb_prev     = 8'h1C;
      tick(1);
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break, overflow} !== 12'h000) begin
         failures++; $display("FAIL during_reset got=%0b/%h/%0b/%0b/%0b exp=all0", evt_valid, evt_code, evt_ext, evt_break, overflow);
      end
      tick(2);
      rst = 1'b0;
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break, overflow} !== 12'h000) begin
         failures++; $display("FAIL after_reset got=%0b/%h/%0b/%0b/%0b exp=all0", evt_valid, evt_code, evt_ext, evt_break, overflow);
      end
      tick(HOLD);
      checks++;
      if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
         failures++; $display("FAIL reset_prefix_drop got=%0b/%h/%0b/%0b exp=1/1c/0/0", evt_valid, evt_code, evt_ext, evt_break);
      end
      pop_one();
   endtask

   // Model: prefix history reduces to two flags; E0 resets the break flag,
   // F0 keeps the extension flag, 00/FF clear both, any other byte emits.
   task automatic test_random();
      logic        m_ext;
      logic        m_brk;
      logic [15:0] m_last_vec;
      logic [15:0] vec;
      logic [7:0]  b;
      logic        exp_evt;
      ps2_evt_t    exp;
      apply_reset();
      m_ext = 1'b0; m_brk = 1'b0; m_last_vec = 16'h0000;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0:       b = BYTE_E0;
            1:       b = BYTE_F0;
            2:       b = ($urandom_range(0, 1) == 0) ? BYTE_00 : BYTE_FF;
            3:       b = tb_prev;
            default: b = 8'($urandom_range(1, 8'hDF));
         endcase
         vec     = {tb_prev, b};
         exp_evt = 1'b0;
         exp     = '0;
         if (vec != m_last_vec) begin
            m_last_vec = vec;
            if (b == BYTE_00 || b == BYTE_FF) begin
               m_ext = 1'b0; m_brk = 1'b0;
            end else if (b == BYTE_E0) begin
               m_ext = 1'b1; m_brk = 1'b0;
            end else if (b == BYTE_F0) begin
               m_brk = 1'b1;
            end else begin
               exp_evt = 1'b1;
               exp     = '{ext: m_ext, brk: m_brk, code: b};
               m_ext = 1'b0; m_brk = 1'b0;
            end
         end
         send_byte(b);
         checks++;
         if (evt_valid !== exp_evt) begin
            failures++; $display("FAIL rand_valid i=%0d byte=%h got=%0b exp=%0b", i, b, evt_valid, exp_evt);
         end
         if (exp_evt) begin
            checks++;
            if ({evt_ext, evt_break, evt_code} !== exp) begin
               failures++; $display("FAIL rand_event i=%0d got=%0b/%0b/%h exp=%0b/%0b/%h",
                                    i, evt_ext, evt_break, evt_code, exp.ext, exp.brk, exp.code);
            end
         end
         if (evt_valid) pop_one();
      end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%0b exp=0", overflow); end
   endtask

   initial begin
      rst         = 1'b1;
      evt_ready   = 1'b0;
      code_vector = 16'h0000;
      #1;
      test_reset();
      test_latency();
      test_ext_break();
      test_overflow();
      test_full_push_pop();
      test_timeout();
      test_reset_mid_prefix();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
